// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } uart_arb_state_t;

    localparam int unsigned UART_BYTE_W           = 8;
    localparam int unsigned UART_N_REQ_DEF        = 4;
    localparam int unsigned UART_MAX_PKT_LEN_DEF  = 256;
    localparam int unsigned UART_IDLE_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester/UART byte-stream bundle for uart_tx_arb.
//   master : requester side (drives req_*, byte_out_ready; observes status)
//   slave  : arbiter side (drives req_ready, byte_out_*, grant/status outputs)
interface uart_tx_arb_if #(
    parameter int unsigned N_REQ = 4
);
    import uart_pkg::*;

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ*UART_BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_last;
    logic [N_REQ-1:0]             req_ready;
    logic [UART_BYTE_W-1:0]       byte_out_data;
    logic                         byte_out_valid;
    logic                         byte_out_ready;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;
    logic                         timeout_pulse;
    logic [7:0]                   timeout_count;

    modport master (
        output req_data, req_valid, req_last, byte_out_ready,
        input  req_ready, byte_out_data, byte_out_valid,
        input  grant_id, busy, timeout_pulse, timeout_count
    );

    modport slave (
        input  req_data, req_valid, req_last, byte_out_ready,
        output req_ready, byte_out_data, byte_out_valid,
        output grant_id, busy, timeout_pulse, timeout_count
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req_vec at or after ptr, wrapping.
//   req_vec : request bits
//   ptr     : search start index
//   any     : at least one request is set
//   idx     : chosen index (0 when any = 0)
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    // Walk N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any && req_vec[(32'(ptr) + i) % N_REQ]) begin
                any = 1'b1;
                idx = ID_W'((32'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART byte stream among
// N_REQ requesters. A grant is held for a whole packet, cut at MAX_PKT_LEN
// bytes, or revoked after IDLE_TIMEOUT cycles without a byte offered.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_arb_if.slave (requester inputs, UART byte output,
//                grant_id / busy / timeout_pulse / timeout_count status)
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = UART_N_REQ_DEF,
    parameter int unsigned MAX_PKT_LEN  = UART_MAX_PKT_LEN_DEF,
    parameter int unsigned IDLE_TIMEOUT = UART_IDLE_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_arb_if.slave bus
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned BCNT_W = (MAX_PKT_LEN  > 1) ? $clog2(MAX_PKT_LEN)  : 1;
    localparam int unsigned ICNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_PKT_LEN - 1);
    localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

    uart_arb_state_t   r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [ICNT_W-1:0] r_idle_cnt;
    logic              r_busy;
    logic              r_timeout_pulse;
    logic [7:0]        r_timeout_count;

    logic              w_any;
    logic [ID_W-1:0]   w_pick_idx;
    logic [ID_W-1:0]   w_next_ptr;
    logic              w_xfer;
    logic              w_g_valid;
    logic              w_g_last;
    logic              w_beat;
    logic              w_release;
    logic              w_timeout;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_vec (bus.req_valid),
        .ptr     (r_rr_ptr),
        .any     (w_any),
        .idx     (w_pick_idx)
    );

    assign w_xfer     = (r_state == XFER);
    assign w_g_valid  = bus.req_valid[r_grant_id];
    assign w_g_last   = bus.req_last[r_grant_id];
    assign w_beat     = w_xfer & w_g_valid & bus.byte_out_ready;
    // Release on the packet's last byte or on the cap-th byte.
    assign w_release  = w_beat & (w_g_last | (r_byte_cnt == BCNT_LAST));
    // A byte offered in the terminal cycle wins over the timeout.
    assign w_timeout  = w_xfer & ~w_g_valid & (r_idle_cnt == ICNT_LAST);
    assign w_next_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_W'(1);

    // Zero-latency pass-through of the granted requester; gated off in IDLE.
    assign bus.byte_out_data  = bus.req_data[{r_grant_id, 3'b000} +: UART_BYTE_W];
    assign bus.byte_out_valid = w_xfer & w_g_valid;
    assign bus.req_ready      = w_xfer ? (N_REQ'(bus.byte_out_ready) << r_grant_id) : '0;

    assign bus.grant_id      = r_grant_id;
    assign bus.busy          = r_busy;
    assign bus.timeout_pulse = r_timeout_pulse;
    assign bus.timeout_count = r_timeout_count;

    // Arbitration FSM, byte/idle counters and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_byte_cnt      <= '0;
            r_idle_cnt      <= '0;
            r_busy          <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_pick_idx;
                        r_state    <= XFER;
                        r_busy     <= 1'b1;
                        r_byte_cnt <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                XFER: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_rr_ptr   <= w_next_ptr;
                        r_byte_cnt <= '0;
                        r_idle_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state         <= IDLE;
                        r_busy          <= 1'b0;
                        r_rr_ptr        <= w_next_ptr;
                        r_byte_cnt      <= '0;
                        r_idle_cnt      <= '0;
                        r_timeout_pulse <= 1'b1;
                        if (r_timeout_count != 8'hFF) begin
                            r_timeout_count <= r_timeout_count + 8'd1;
                        end
                    end else if (w_beat) begin
                        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                        r_idle_cnt <= '0;
                    end else if (!w_g_valid) begin
                        // Backpressure with valid high holds the idle count.
                        r_idle_cnt <= r_idle_cnt + ICNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (N_REQ=4, MAX_PKT_LEN=4, IDLE_TIMEOUT=16).
module tb_uart_tx_arb;

    localparam int unsigned NR = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic [NR*8-1:0] data;
        logic [NR-1:0]   valid;
        logic [NR-1:0]   last;
        logic            ready;
        logic            e_valid;
        logic [7:0]      e_data;
        logic [NR-1:0]   e_ready;
        logic            e_busy;
        logic [1:0]      e_gid;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    int          tp_seen  = 0;
    logic [8:0]  txq [NR][$];
    sb_t         exp_q [$];
    logic [NR-1:0] acc = '0;
    vec_t        vecs [10];

    uart_tx_arb_if #(.N_REQ(NR)) bus ();

    uart_tx_arb #(
        .N_REQ        (NR),
        .MAX_PKT_LEN  (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [3:0] v, input logic [3:0] l,
                                input logic r, input logic ev, input logic [7:0] ed,
                                input logic [3:0] er, input logic eb, input logic [1:0] eg);
        vec_t t;
        t.data = d; t.valid = v; t.last = l; t.ready = r;
        t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_busy = eb; t.e_gid = eg;
        return t;
    endfunction

    task automatic load_pkt(input int id, input logic [7:0] first, input int n, input logic last_end);
        for (int k = 0; k < n; k++) begin
            txq[id].push_back({(last_end && (k == n - 1)), 8'(first + 8'(k))});
        end
    endtask

    task automatic expect_seq(input int id, input logic [7:0] first, input int n);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = 2'(id);
            e.data = 8'(first + 8'(k));
            exp_q.push_back(e);
        end
    endtask

    // Requester model: retire bytes accepted at the last edge, present the next head.
    task automatic drive_reqs(input logic rdy);
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && txq[i].size() != 0) void'(txq[i].pop_front());
        end
        acc = '0;
        for (int i = 0; i < NR; i++) begin
            if (txq[i].size() != 0) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_data[i*8 +: 8]  = txq[i][0][7:0];
                bus.req_last[i]         = txq[i][0][8];
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[i*8 +: 8]  = 8'h00;
                bus.req_last[i]         = 1'b0;
            end
        end
        bus.byte_out_ready = rdy;
    endtask

    // Observe the cycle before the next edge: record handshakes, score UART beats.
    task automatic sample();
        sb_t e;
        acc = rst_n ? (bus.req_valid & bus.req_ready) : '0;
        if (bus.timeout_pulse) tp_seen++;
        if (rst_n && bus.byte_out_valid && bus.byte_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra_byte: got id=%0d data=0x%0h with nothing expected",
                         bus.grant_id, bus.byte_out_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_id", 32'(bus.grant_id), 32'(e.id));
                chk("sb_data", 32'(bus.byte_out_data), 32'(e.data));
            end
        end
    endtask

    task automatic step(input logic rdy);
        @(posedge clk);
        #2;
        drive_reqs(rdy);
        @(negedge clk);
        #1;
        sample();
    endtask

    task automatic run_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b1);
            n++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid      = '0;
        bus.req_last       = '0;
        bus.req_data       = '0;
        bus.byte_out_ready = 1'b0;
        for (int i = 0; i < NR; i++) txq[i].delete();
        exp_q.delete();
        acc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int beat_c;
        int pulse_c;
        int tp0;
        int beats;

        // Single-requester packet, then rr_ptr probes via simultaneous requests.
        vecs[0] = mk(32'h0000_4100, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        vecs[1] = mk(32'h0000_4100, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h41, 4'b0010, 1'b1, 2'd1);
        vecs[2] = mk(32'h0000_4200, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h42, 4'b0010, 1'b1, 2'd1);
        vecs[3] = mk(32'h0000_4300, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'h43, 4'b0010, 1'b1, 2'd1);
        vecs[4] = mk(32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
        vecs[5] = mk(32'h3300_1100, 4'b1010, 4'b1010, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
        vecs[6] = mk(32'h3300_1100, 4'b1010, 4'b1010, 1'b1, 1'b1, 8'h33, 4'b1000, 1'b1, 2'd3);
        vecs[7] = mk(32'h0000_1100, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);
        vecs[8] = mk(32'h0000_1100, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1);
        vecs[9] = mk(32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);

        // Reset state, with requests and ready asserted during reset.
        bus.req_valid      = 4'b1111;
        bus.req_last       = 4'b0000;
        bus.req_data       = 32'hDEAD_BEEF;
        bus.byte_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.byte_out_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_timeout_pulse", 32'(bus.timeout_pulse), 32'd0);
        chk("rst_timeout_count", 32'(bus.timeout_count), 32'd0);
        bus.req_valid = '0;
        bus.req_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            bus.req_data       = vecs[k].data;
            bus.req_valid      = vecs[k].valid;
            bus.req_last       = vecs[k].last;
            bus.byte_out_ready = vecs[k].ready;
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", k), 32'(bus.byte_out_valid), 32'(vecs[k].e_valid));
            if (vecs[k].e_valid) chk($sformatf("vec%0d_out_data", k), 32'(bus.byte_out_data), 32'(vecs[k].e_data));
            chk($sformatf("vec%0d_req_ready", k), 32'(bus.req_ready), 32'(vecs[k].e_ready));
            chk($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vecs[k].e_busy));
            chk($sformatf("vec%0d_grant_id", k), 32'(bus.grant_id), 32'(vecs[k].e_gid));
            chk($sformatf("vec%0d_timeout_pulse", k), 32'(bus.timeout_pulse), 32'd0);
        end

        // Two requesters from reset: 0, then 2, then 0 again; no interleave.
        do_reset();
        load_pkt(0, 8'hA0, 2, 1'b1);
        load_pkt(0, 8'hC0, 2, 1'b1);
        load_pkt(2, 8'hB0, 2, 1'b1);
        expect_seq(0, 8'hA0, 2);
        expect_seq(2, 8'hB0, 2);
        expect_seq(0, 8'hC0, 2);
        run_drain("t2", 40);

        // Backpressure on requester 3, including a stall longer than the timeout.
        load_pkt(3, 8'hD0, 4, 1'b1);
        expect_seq(3, 8'hD0, 4);
        tp0   = tp_seen;
        beats = 0;
        for (int c = 0; c < 28; c++) begin
            logic r3;
            logic g3;
            r3 = (c <= 1) || (c == 4) || (c >= 25);
            g3 = (c >= 1) && (beats < 4);
            step(r3);
            chk("t3_req_ready", 32'(bus.req_ready), 32'(g3 ? {r3, 3'b000} : 4'b0000));
            chk("t3_busy", 32'(bus.busy), 32'(g3));
            if (g3 && r3) beats++;
        end
        chk("t3_no_timeout", 32'(tp_seen - tp0), 32'd0);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Idle timeout: requester 0 sends one byte without last, requester 1 waits.
        load_pkt(0, 8'h50, 1, 1'b0);
        load_pkt(1, 8'h60, 2, 1'b1);
        expect_seq(0, 8'h50, 1);
        expect_seq(1, 8'h60, 2);
        tp0     = tp_seen;
        beat_c  = -1;
        pulse_c = -1;
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            if (beat_c < 0 && bus.byte_out_valid && bus.grant_id == 2'd0) beat_c = c;
            if (bus.timeout_pulse && pulse_c < 0) begin
                pulse_c = c;
                chk("t4_busy_at_pulse", 32'(bus.busy), 32'd0);
            end
        end
        chk("t4_timeout_latency", 32'(pulse_c - beat_c), 32'd17);
        chk("t4_pulse_count", 32'(tp_seen - tp0), 32'd1);
        chk("t4_timeout_count", 32'(bus.timeout_count), 32'd1);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Byte cap: 6-byte packet from 2 is split around requester 3's packet.
        do_reset();
        chk("t5_count_after_reset", 32'(bus.timeout_count), 32'd0);
        load_pkt(2, 8'h20, 6, 1'b1);
        load_pkt(3, 8'h30, 2, 1'b1);
        expect_seq(2, 8'h20, 4);
        expect_seq(3, 8'h30, 2);
        expect_seq(2, 8'h24, 2);
        run_drain("t5", 40);

        // Asynchronous reset mid-packet, then arbitration restarts at requester 0.
        load_pkt(1, 8'h70, 5, 1'b1);
        expect_seq(1, 8'h70, 5);
        repeat (3) step(1'b1);
        chk("t6_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_out_valid", 32'(bus.byte_out_valid), 32'd0);
        chk("t6_req_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_grant_id", 32'(bus.grant_id), 32'd0);
        do_reset();
        load_pkt(3, 8'h3A, 1, 1'b1);
        load_pkt(0, 8'h0A, 1, 1'b1);
        expect_seq(0, 8'h0A, 1);
        expect_seq(3, 8'h3A, 1);
        run_drain("t6", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
